// File: rtl/cio_controller.sv
// Console I/O controller: buffers keyboard symbols in a small FIFO, serves
// decoder CIN requests from it, forwards COUT symbols to the terminal over a
// valid/ready handshake, and runs the four-phase request/acknowledge protocol
// towards the instruction decoder.
module cio_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  CinReq,
  input  logic                  CoutReq,
  input  logic [DATA_WIDTH-1:0] CoutData,
  output logic                  CioAcq,
  output logic [DATA_WIDTH-1:0] CinData,
  input  logic                  RxStrobe,
  input  logic [DATA_WIDTH-1:0] RxData,
  output logic                  TxValid,
  output logic [DATA_WIDTH-1:0] TxData,
  input  logic                  TxReady,
  output logic [FIFO_AW:0]      FifoCount,
  output logic                  RxOverflow,
  input  logic                  OvfClr,
  output logic                  ProtoErr
);

  localparam int CNT_W = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CIN_WAIT = 2'd1,
    TX       = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t state, stateNext;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wrPtr, rdPtr;
  logic [CNT_W-1:0]      count;
  logic                  fifoEmpty, fifoFull;
  logic                  push, pop, drop;
  logic [DATA_WIDTH-1:0] fifoHead;

  // Which request the current ACK belongs to (1 = CIN, 0 = COUT)
  logic isCin, isCinNext;
  logic activeReq;

  // Next values of registered outputs
  logic                  cioAcqNext;
  logic [DATA_WIDTH-1:0] cinDataNext;
  logic                  txValidNext;
  logic [DATA_WIDTH-1:0] txDataNext;
  logic                  protoErrNext;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == DEPTH_C);
  assign fifoHead  = mem[rdPtr];
  assign activeReq = isCin ? CinReq : CoutReq;

  // A pop happens only when the decoder is still asking and data is present.
  assign pop  = (state == CIN_WAIT) && CinReq && !fifoEmpty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds.
  assign push = RxStrobe && (!fifoFull || pop);
  assign drop = RxStrobe && !push;

  // FIFO data array; contents need no reset since pointers define validity
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wrPtr] <= RxData;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      RxOverflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        RxOverflow <= 1'b1;
      end else if (OvfClr) begin
        RxOverflow <= 1'b0;
      end
    end
  end

  assign FifoCount = count;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (CoutReq) begin
          stateNext = TX;
        end else if (CinReq) begin
          stateNext = CIN_WAIT;
        end
      end
      CIN_WAIT: begin
        if (!CinReq) begin
          stateNext = IDLE;
        end else if (!fifoEmpty) begin
          stateNext = ACK;
        end
      end
      TX: begin
        if (TxValid && TxReady) begin
          stateNext = ACK;
        end
      end
      ACK: begin
        if (!activeReq) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake outputs
  always_comb begin
    cioAcqNext   = CioAcq;
    cinDataNext  = CinData;
    txValidNext  = TxValid;
    txDataNext   = TxData;
    protoErrNext = ProtoErr;
    isCinNext    = isCin;
    case (state)
      IDLE: begin
        cioAcqNext = 1'b0;
        if (CoutReq) begin
          txDataNext  = CoutData;
          txValidNext = 1'b1;
          isCinNext   = 1'b0;
          if (CinReq) begin
            protoErrNext = 1'b1;
          end
        end else if (CinReq) begin
          isCinNext = 1'b1;
        end
      end
      CIN_WAIT: begin
        if (pop) begin
          cinDataNext = fifoHead;
          cioAcqNext  = 1'b1;
        end
      end
      TX: begin
        if (TxValid && TxReady) begin
          txValidNext = 1'b0;
          cioAcqNext  = 1'b1;
        end
      end
      ACK: begin
        if (!activeReq) begin
          cioAcqNext = 1'b0;
        end
      end
      default: begin
        cioAcqNext  = 1'b0;
        txValidNext = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      CioAcq   <= 1'b0;
      CinData  <= '0;
      TxValid  <= 1'b0;
      TxData   <= '0;
      ProtoErr <= 1'b0;
      isCin    <= 1'b0;
    end else begin
      CioAcq   <= cioAcqNext;
      CinData  <= cinDataNext;
      TxValid  <= txValidNext;
      TxData   <= txDataNext;
      ProtoErr <= protoErrNext;
      isCin    <= isCinNext;
    end
  end

endmodule

// File: tb/tb_cio_controller.sv
// Directed testbench for cio_controller: FIFO buffering, CIN/COUT
// handshakes, overflow handling and reset abort.
module tb_cio_controller;

  logic       Clk;
  logic       Rst_n;
  logic       CinReq;
  logic       CoutReq;
  logic [7:0] CoutData;
  logic       CioAcq;
  logic [7:0] CinData;
  logic       RxStrobe;
  logic [7:0] RxData;
  logic       TxValid;
  logic [7:0] TxData;
  logic       TxReady;
  logic [2:0] FifoCount;
  logic       RxOverflow;
  logic       OvfClr;
  logic       ProtoErr;

  int unsigned checkCnt = 0;
  int unsigned passCnt  = 0;

  cio_controller #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .FIFO_AW(2)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .CinReq(CinReq),
    .CoutReq(CoutReq),
    .CoutData(CoutData),
    .CioAcq(CioAcq),
    .CinData(CinData),
    .RxStrobe(RxStrobe),
    .RxData(RxData),
    .TxValid(TxValid),
    .TxData(TxData),
    .TxReady(TxReady),
    .FifoCount(FifoCount),
    .RxOverflow(RxOverflow),
    .OvfClr(OvfClr),
    .ProtoErr(ProtoErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d);
    RxStrobe = 1'b1;
    RxData   = d;
    tick();
    RxStrobe = 1'b0;
  endtask

  // Full CIN transaction with a bounded wait for the acknowledge
  task automatic doCin(input string tag, input logic [7:0] exp);
    CinReq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (CioAcq) break;
    end
    checkVal({tag, "_acq"}, CioAcq, 1);
    checkVal({tag, "_data"}, CinData, exp);
    CinReq = 1'b0;
    tick();
    checkVal({tag, "_acqdrop"}, CioAcq, 0);
  endtask

  logic sawAcq;
  logic txStable;

  initial begin
    Rst_n = 1'b0; CinReq = 1'b0; CoutReq = 1'b0; CoutData = '0;
    RxStrobe = 1'b0; RxData = '0; TxReady = 1'b0; OvfClr = 1'b0;
    repeat (3) tick();
    checkVal("rst_acq", CioAcq, 0);
    checkVal("rst_cindata", CinData, 0);
    checkVal("rst_txvalid", TxValid, 0);
    checkVal("rst_txdata", TxData, 0);
    checkVal("rst_count", FifoCount, 0);
    checkVal("rst_ovf", RxOverflow, 0);
    checkVal("rst_perr", ProtoErr, 0);
    Rst_n = 1'b1;
    tick();

    // Basic CIN with two-clock latency
    pushByte(8'h41);
    pushByte(8'h42);
    checkVal("t1_count2", FifoCount, 2);
    CinReq = 1'b1;
    tick();
    checkVal("t1_acq_early", CioAcq, 0);
    tick();
    checkVal("t1_acq", CioAcq, 1);
    checkVal("t1_data", CinData, 8'h41);
    checkVal("t1_count1", FifoCount, 1);
    tick();
    checkVal("t1_acq_hold", CioAcq, 1);
    CinReq = 1'b0;
    tick();
    checkVal("t1_acqdrop", CioAcq, 0);
    doCin("t1_second", 8'h42);
    checkVal("t1_count0", FifoCount, 0);

    // CIN waiting on an empty FIFO
    CinReq = 1'b1;
    sawAcq = 1'b0;
    repeat (10) begin
      tick();
      if (CioAcq) sawAcq = 1'b1;
    end
    checkVal("t2_noacq_empty", sawAcq, 0);
    RxStrobe = 1'b1;
    RxData   = 8'h30;
    tick();
    RxStrobe = 1'b0;
    checkVal("t2_acq_pushedge", CioAcq, 0);
    tick();
    checkVal("t2_acq", CioAcq, 1);
    checkVal("t2_data", CinData, 8'h30);
    CinReq = 1'b0;
    tick();
    checkVal("t2_acqdrop", CioAcq, 0);

    // COUT with terminal back-pressure; CoutData changes must not leak through
    CoutData = 8'h48;
    CoutReq  = 1'b1;
    tick();
    CoutData = 8'h00;
    checkVal("t3_txvalid", TxValid, 1);
    checkVal("t3_txdata", TxData, 8'h48);
    txStable = 1'b1;
    repeat (5) begin
      tick();
      if (TxValid !== 1'b1 || TxData !== 8'h48 || CioAcq !== 1'b0) txStable = 1'b0;
    end
    checkVal("t3_stable", txStable, 1);
    TxReady = 1'b1;
    tick();
    TxReady = 1'b0;
    checkVal("t3_txvalid_done", TxValid, 0);
    checkVal("t3_acq", CioAcq, 1);
    CoutReq = 1'b0;
    tick();
    checkVal("t3_acqdrop", CioAcq, 0);

    // Overflow: fifth byte dropped
    for (int i = 1; i <= 5; i++) pushByte(8'(i));
    checkVal("t4_count", FifoCount, 4);
    checkVal("t4_ovf", RxOverflow, 1);
    doCin("t4_rd1", 8'h01);
    doCin("t4_rd2", 8'h02);
    doCin("t4_rd3", 8'h03);
    doCin("t4_rd4", 8'h04);
    checkVal("t4_ovf_sticky", RxOverflow, 1);
    OvfClr = 1'b1;
    tick();
    OvfClr = 1'b0;
    checkVal("t4_ovfclr", RxOverflow, 0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 5; i <= 8; i++) pushByte(8'(i));
    checkVal("t5_full", FifoCount, 4);
    CinReq = 1'b1;
    tick();
    RxStrobe = 1'b1;
    RxData   = 8'h09;
    tick();
    RxStrobe = 1'b0;
    checkVal("t5_count", FifoCount, 4);
    checkVal("t5_ovf", RxOverflow, 0);
    checkVal("t5_acq", CioAcq, 1);
    checkVal("t5_data", CinData, 8'h05);
    CinReq = 1'b0;
    tick();
    doCin("t5_rd6", 8'h06);
    doCin("t5_rd7", 8'h07);
    doCin("t5_rd8", 8'h08);
    doCin("t5_rd9", 8'h09);
    checkVal("t5_empty", FifoCount, 0);

    // Dropping push and OvfClr together: set wins
    for (int i = 10; i <= 13; i++) pushByte(8'(i));
    RxStrobe = 1'b1;
    RxData   = 8'hEE;
    OvfClr   = 1'b1;
    tick();
    RxStrobe = 1'b0;
    OvfClr   = 1'b0;
    checkVal("t6_setwins", RxOverflow, 1);
    checkVal("t6_count", FifoCount, 4);

    // Reset during ACK of a CIN with two bytes left
    doCin("t7_rd", 8'h0A);
    CinReq = 1'b1;
    tick();
    tick();
    checkVal("t7_acq", CioAcq, 1);
    checkVal("t7_data", CinData, 8'h0B);
    checkVal("t7_count2", FifoCount, 2);
    Rst_n = 1'b0;
    #1;
    checkVal("t7_rst_acq", CioAcq, 0);
    checkVal("t7_rst_count", FifoCount, 0);
    checkVal("t7_rst_ovf", RxOverflow, 0);
    CinReq = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    checkVal("t7_idle_acq", CioAcq, 0);

    // Both requests together: protocol error, COUT served
    CoutData = 8'h55;
    CinReq   = 1'b1;
    CoutReq  = 1'b1;
    TxReady  = 1'b1;
    tick();
    checkVal("t8_perr", ProtoErr, 1);
    checkVal("t8_txvalid", TxValid, 1);
    checkVal("t8_txdata", TxData, 8'h55);
    tick();
    checkVal("t8_txdone", TxValid, 0);
    checkVal("t8_acq", CioAcq, 1);
    CinReq  = 1'b0;
    CoutReq = 1'b0;
    TxReady = 1'b0;
    tick();
    checkVal("t8_acqdrop", CioAcq, 0);
    checkVal("t8_perr_sticky", ProtoErr, 1);
    checkVal("t8_count", FifoCount, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
